encoder_8b10b: RTL and testbench

Synchronous IEEE 802.3-style 8b/10b line encoder with running-disparity tracking. It accepts one byte per clock on a qualified input, maps it to a DC-balanced 10-bit symbol, and registers the result. It inserts K28.5 comma symbols when no data is offered. It sits between the byte-wide datapath and the serializer of the transmit lane.

---
 rtl/encoder_8b10b_if.sv | 19 +
 rtl/encoder_8b10b.sv | 142 ++++++++++++++
 tb/tb_encoder_8b10b.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_8b10b_if.sv
// Byte-in / symbol-out bundle for encoder_8b10b.
// k_i exists only when ENC8B10B_KCHAR_EN is defined.
interface encoder_8b10b_if;
  logic       enable_i;
  logic       valid_i;
  logic [7:0] data_i;
`ifdef ENC8B10B_KCHAR_EN
  logic       k_i;
`endif
  logic [9:0] out10b_o;

`ifdef ENC8B10B_KCHAR_EN
  modport master (output enable_i, valid_i, data_i, k_i, input out10b_o);
  modport slave  (input enable_i, valid_i, data_i, k_i, output out10b_o);
`else
  modport master (output enable_i, valid_i, data_i, input out10b_o);
  modport slave  (input enable_i, valid_i, data_i, output out10b_o);
`endif
endinterface

// File: rtl/encoder_8b10b.sv
// 8b/10b line encoder with running disparity; idles as K28.5.
// Optional control-character input enabled by ENC8B10B_KCHAR_EN.
module encoder_8b10b (
  input  logic             clk_i,
  input  logic             rst_ni,
  encoder_8b10b_if.slave   bus
);

  logic [9:0] out10b_q, out10b_d;
  logic       rd_q, rd_d;
  logic       isK;
  logic [4:0] xVal;
  logic [2:0] yVal;
  logic [5:0] code6Neg, sym6;
  logic [3:0] code4Neg, sym4;
  logic       unbal6, unbal4, rdMid, useAlt;

`ifdef ENC8B10B_KCHAR_EN
  logic kSupported;
  assign kSupported = (bus.data_i[4:0] == 5'd28) ||
                      ((bus.data_i[7:5] == 3'd7) &&
                       ((bus.data_i[4:0] == 5'd23) || (bus.data_i[4:0] == 5'd27) ||
                        (bus.data_i[4:0] == 5'd29) || (bus.data_i[4:0] == 5'd30)));
`endif

  // Idle and unsupported control characters both collapse to K28.5.
  always_comb begin
    isK  = 1'b0;
    xVal = bus.data_i[4:0];
    yVal = bus.data_i[7:5];
    if (!bus.valid_i) begin
      isK  = 1'b1;
      xVal = 5'd28;
      yVal = 3'd5;
    end
`ifdef ENC8B10B_KCHAR_EN
    else if (bus.k_i) begin
      isK = 1'b1;
      if (!kSupported) begin
        xVal = 5'd28;
        yVal = 3'd5;
      end
    end
`endif
  end

  // 5b/6b lookup in its RD- form; RD+ is the complement when the code is unbalanced or D.7.
  always_comb begin
    code6Neg = 6'b000000;
    case (xVal)
      5'd0:  code6Neg = 6'b100111;
      5'd1:  code6Neg = 6'b011101;
      5'd2:  code6Neg = 6'b101101;
      5'd3:  code6Neg = 6'b110001;
      5'd4:  code6Neg = 6'b110101;
      5'd5:  code6Neg = 6'b101001;
      5'd6:  code6Neg = 6'b011001;
      5'd7:  code6Neg = 6'b111000;
      5'd8:  code6Neg = 6'b111001;
      5'd9:  code6Neg = 6'b100101;
      5'd10: code6Neg = 6'b010101;
      5'd11: code6Neg = 6'b110100;
      5'd12: code6Neg = 6'b001101;
      5'd13: code6Neg = 6'b101100;
      5'd14: code6Neg = 6'b011100;
      5'd15: code6Neg = 6'b010111;
      5'd16: code6Neg = 6'b011011;
      5'd17: code6Neg = 6'b100011;
      5'd18: code6Neg = 6'b010011;
      5'd19: code6Neg = 6'b110010;
      5'd20: code6Neg = 6'b001011;
      5'd21: code6Neg = 6'b101010;
      5'd22: code6Neg = 6'b011010;
      5'd23: code6Neg = 6'b111010;
      5'd24: code6Neg = 6'b110011;
      5'd25: code6Neg = 6'b100110;
      5'd26: code6Neg = 6'b010110;
      5'd27: code6Neg = 6'b110110;
      5'd28: code6Neg = isK ? 6'b001111 : 6'b001110;
      5'd29: code6Neg = 6'b101110;
      5'd30: code6Neg = 6'b011110;
      5'd31: code6Neg = 6'b101011;
      default: code6Neg = 6'b000000;
    endcase
    unbal6 = ($countones(code6Neg) != 3);
    sym6   = (rd_q && (unbal6 || (xVal == 5'd7 && !isK))) ? ~code6Neg : code6Neg;
    rdMid  = rd_q ^ unbal6;
  end

  // 3b/4b lookup keyed on the disparity left by the 6b sub-block.
  always_comb begin
    code4Neg = 4'b0000;
    useAlt   = rd_q ? ((xVal == 5'd11) || (xVal == 5'd13) || (xVal == 5'd14))
                    : ((xVal == 5'd17) || (xVal == 5'd18) || (xVal == 5'd20));
    if (isK) begin
      case (yVal)
        3'd0: code4Neg = 4'b1011;
        3'd1: code4Neg = 4'b0110;
        3'd2: code4Neg = 4'b1010;
        3'd3: code4Neg = 4'b1100;
        3'd4: code4Neg = 4'b1101;
        3'd5: code4Neg = 4'b0101;
        3'd6: code4Neg = 4'b1001;
        3'd7: code4Neg = 4'b0111;
        default: code4Neg = 4'b0000;
      endcase
    end else begin
      case (yVal)
        3'd0: code4Neg = 4'b1011;
        3'd1: code4Neg = 4'b1001;
        3'd2: code4Neg = 4'b0101;
        3'd3: code4Neg = 4'b1100;
        3'd4: code4Neg = 4'b1101;
        3'd5: code4Neg = 4'b1010;
        3'd6: code4Neg = 4'b0110;
        3'd7: code4Neg = useAlt ? 4'b0111 : 4'b1110;
        default: code4Neg = 4'b0000;
      endcase
    end
    unbal4 = ($countones(code4Neg) != 2);
    sym4   = (rdMid && (isK || unbal4 || yVal == 3'd3)) ? ~code4Neg : code4Neg;
    rd_d   = rdMid ^ unbal4;
  end

  assign out10b_d = {sym6, sym4};

  // Disabled cycles blank the line but keep the disparity for the next symbol.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out10b_q <= 10'b0;
      rd_q     <= 1'b0;
    end else if (!bus.enable_i) begin
      out10b_q <= 10'b0;
    end else begin
      out10b_q <= out10b_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.out10b_o = out10b_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Self-checking bench for encoder_8b10b: directed vectors plus random traffic
// against a two-column table model of the 8b/10b code.
module tb_encoder_8b10b;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   total = 0;
  int   bad = 0;

  encoder_8b10b_if bus ();
  encoder_8b10b dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  logic [5:0] d6n [32];
  logic [5:0] d6p [32];
  logic [3:0] d4n [8];
  logic [3:0] d4p [8];
  logic [3:0] k4n [8];
  logic [3:0] k4p [8];
  logic       mRd;

  task automatic initTables();
    d6n[0]=6'b100111; d6n[1]=6'b011101; d6n[2]=6'b101101; d6n[3]=6'b110001;
    d6n[4]=6'b110101; d6n[5]=6'b101001; d6n[6]=6'b011001; d6n[7]=6'b111000;
    d6n[8]=6'b111001; d6n[9]=6'b100101; d6n[10]=6'b010101; d6n[11]=6'b110100;
    d6n[12]=6'b001101; d6n[13]=6'b101100; d6n[14]=6'b011100; d6n[15]=6'b010111;
    d6n[16]=6'b011011; d6n[17]=6'b100011; d6n[18]=6'b010011; d6n[19]=6'b110010;
    d6n[20]=6'b001011; d6n[21]=6'b101010; d6n[22]=6'b011010; d6n[23]=6'b111010;
    d6n[24]=6'b110011; d6n[25]=6'b100110; d6n[26]=6'b010110; d6n[27]=6'b110110;
    d6n[28]=6'b001110; d6n[29]=6'b101110; d6n[30]=6'b011110; d6n[31]=6'b101011;
    d6p[0]=6'b011000; d6p[1]=6'b100010; d6p[2]=6'b010010; d6p[3]=6'b110001;
    d6p[4]=6'b001010; d6p[5]=6'b101001; d6p[6]=6'b011001; d6p[7]=6'b000111;
    d6p[8]=6'b000110; d6p[9]=6'b100101; d6p[10]=6'b010101; d6p[11]=6'b110100;
    d6p[12]=6'b001101; d6p[13]=6'b101100; d6p[14]=6'b011100; d6p[15]=6'b101000;
    d6p[16]=6'b100100; d6p[17]=6'b100011; d6p[18]=6'b010011; d6p[19]=6'b110010;
    d6p[20]=6'b001011; d6p[21]=6'b101010; d6p[22]=6'b011010; d6p[23]=6'b000101;
    d6p[24]=6'b001100; d6p[25]=6'b100110; d6p[26]=6'b010110; d6p[27]=6'b001001;
    d6p[28]=6'b001110; d6p[29]=6'b010001; d6p[30]=6'b100001; d6p[31]=6'b010100;
    d4n[0]=4'b1011; d4n[1]=4'b1001; d4n[2]=4'b0101; d4n[3]=4'b1100;
    d4n[4]=4'b1101; d4n[5]=4'b1010; d4n[6]=4'b0110; d4n[7]=4'b1110;
    d4p[0]=4'b0100; d4p[1]=4'b1001; d4p[2]=4'b0101; d4p[3]=4'b0011;
    d4p[4]=4'b0010; d4p[5]=4'b1010; d4p[6]=4'b0110; d4p[7]=4'b0001;
    k4n[0]=4'b1011; k4n[1]=4'b0110; k4n[2]=4'b1010; k4n[3]=4'b1100;
    k4n[4]=4'b1101; k4n[5]=4'b0101; k4n[6]=4'b1001; k4n[7]=4'b0111;
    k4p[0]=4'b0100; k4p[1]=4'b1001; k4p[2]=4'b0101; k4p[3]=4'b0011;
    k4p[4]=4'b0010; k4p[5]=4'b1010; k4p[6]=4'b0110; k4p[7]=4'b1000;
  endtask

  // Reference model: table lookup by disparity column, rd from the symbol's ones count.
  task automatic modelStep(input logic en, input logic val, input logic k,
                           input logic [7:0] d, output logic [9:0] expSym);
    int x, y;
    logic ctl, r1;
    logic [5:0] s6;
    logic [3:0] s4;
    if (!en) begin
      expSym = 10'b0;
      return;
    end
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    ctl = k;
    if (!val) begin ctl = 1'b1; x = 28; y = 5; end
    else if (k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)))) begin
      x = 28; y = 5;
    end
    if (ctl && x == 28) s6 = mRd ? 6'b110000 : 6'b001111;
    else                s6 = mRd ? d6p[x] : d6n[x];
    r1 = mRd ^ ($countones(s6) != 3);
    if (ctl)
      s4 = r1 ? k4p[y] : k4n[y];
    else if (y == 7 && ((!mRd && (x == 17 || x == 18 || x == 20)) ||
                        (mRd && (x == 11 || x == 13 || x == 14))))
      s4 = r1 ? 4'b1000 : 4'b0111;
    else
      s4 = r1 ? d4p[y] : d4n[y];
    expSym = {s6, s4};
    mRd = mRd ^ ($countones(expSym) != 5);
  endtask

  task automatic drive(input logic en, input logic val, input logic k, input logic [7:0] d);
    bus.enable_i = en;
    bus.valid_i  = val;
    bus.data_i   = d;
`ifdef ENC8B10B_KCHAR_EN
    bus.k_i      = k;
`endif
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    mRd = 1'b0;
    total++;
    if (bus.out10b_o !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_out got=%b exp=%b", bus.out10b_o, 10'b0);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0]  dat [7];
    logic        vld [7];
    logic [9:0]  want [7];
    logic [9:0]  m;
    dat[0]=8'h00; vld[0]=1; want[0]=10'b1001110100;
    dat[1]=8'h01; vld[1]=1; want[1]=10'b0111010100;
    dat[2]=8'hF7; vld[2]=1; want[2]=10'b1110100001;
    dat[3]=8'h00; vld[3]=0; want[3]=10'b0011111010;
    dat[4]=8'h00; vld[4]=1; want[4]=10'b0110001011;
    dat[5]=8'hB5; vld[5]=1; want[5]=10'b1010101010;
    dat[6]=8'h00; vld[6]=0; want[6]=10'b1100000101;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vld[i], 1'b0, dat[i]);
      modelStep(1'b1, vld[i], 1'b0, dat[i], m);
      total++;
      if (bus.out10b_o !== want[i]) begin
        bad++;
        $display("[TB] FAIL vector%0d got=%b exp=%b", i, bus.out10b_o, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] m;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'hB5);
      modelStep(1'b1, 1'b1, 1'b0, 8'hB5, m);
      total++;
      if (bus.out10b_o !== 10'b1010101010) begin
        bad++;
        $display("[TB] FAIL d21_5_rd%0b got=%b exp=%b", mRd, bus.out10b_o, 10'b1010101010);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      modelStep(1'b1, 1'b0, 1'b0, 8'h00, m);
    end
  endtask

  task automatic test_enable_gap();
    logic [9:0] m;
    if (!mRd) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      modelStep(1'b1, 1'b0, 1'b0, 8'h00, m);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    modelStep(1'b0, 1'b1, 1'b0, 8'h00, m);
    total++;
    if (bus.out10b_o !== 10'b0) begin
      bad++;
      $display("[TB] FAIL disabled_out got=%b exp=%b", bus.out10b_o, 10'b0);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    modelStep(1'b1, 1'b1, 1'b0, 8'h00, m);
    total++;
    if (bus.out10b_o !== 10'b0110001011) begin
      bad++;
      $display("[TB] FAIL reenable_rd got=%b exp=%b", bus.out10b_o, 10'b0110001011);
    end
  endtask

  task automatic test_reset_midstream();
    logic [9:0] m;
    if (!mRd) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      modelStep(1'b1, 1'b0, 1'b0, 8'h00, m);
    end
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    mRd = 1'b0;
    total++;
    if (bus.out10b_o !== 10'b0) begin
      bad++;
      $display("[TB] FAIL midreset_out got=%b exp=%b", bus.out10b_o, 10'b0);
    end
    rst_ni = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    modelStep(1'b1, 1'b1, 1'b0, 8'h00, m);
    total++;
    if (bus.out10b_o !== 10'b1001110100) begin
      bad++;
      $display("[TB] FAIL after_reset got=%b exp=%b", bus.out10b_o, 10'b1001110100);
    end
  endtask

`ifdef ENC8B10B_KCHAR_EN
  task automatic test_kchar();
    logic [9:0] m;
    rst_ni = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    mRd = 1'b0;
    rst_ni = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hBC);
    modelStep(1'b1, 1'b1, 1'b1, 8'hBC, m);
    total++;
    if (bus.out10b_o !== 10'b0011111010) begin
      bad++;
      $display("[TB] FAIL k28_5 got=%b exp=%b", bus.out10b_o, 10'b0011111010);
    end
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    modelStep(1'b1, 1'b1, 1'b1, 8'h00, m);
    total++;
    if (bus.out10b_o !== 10'b1100000101) begin
      bad++;
      $display("[TB] FAIL invalid_k got=%b exp=%b", bus.out10b_o, 10'b1100000101);
    end
  endtask
`endif

  task automatic test_random();
    logic [9:0] m;
    logic       en, val, k;
    logic [7:0] d;
    logic [4:0] kx [5];
    kx[0]=5'd28; kx[1]=5'd23; kx[2]=5'd27; kx[3]=5'd29; kx[4]=5'd30;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      val = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      k   = 1'b0;
`ifdef ENC8B10B_KCHAR_EN
      k = ($urandom_range(0, 5) == 0);
      if (k && $urandom_range(0, 1) == 1) begin
        d[4:0] = kx[$urandom_range(0, 4)];
        if (d[4:0] != 5'd28) d[7:5] = 3'd7;
      end
`endif
      drive(en, val, k, d);
      modelStep(en, val, k, d, m);
      total++;
      if (bus.out10b_o !== m) begin
        bad++;
        $display("[TB] FAIL random%0d en=%b v=%b k=%b d=%h got=%b exp=%b",
                 i, en, val, k, d, bus.out10b_o, m);
      end
    end
  endtask

  initial begin
    initTables();
    mRd = 1'b0;
    rst_ni = 1'b0;
    bus.enable_i = 1'b0;
    bus.valid_i  = 1'b0;
    bus.data_i   = 8'h00;
`ifdef ENC8B10B_KCHAR_EN
    bus.k_i      = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_back_to_back();
    test_enable_gap();
    test_reset_midstream();
`ifdef ENC8B10B_KCHAR_EN
    test_kchar();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
